// File: rtl/wb_dma_qch_ret_ctrl.sv
// Q-channel retention sequencer for wb_dma: drain, save, isolate and gate on request,
// and run the reverse sequence on wake. Denies the request if the DMA stays busy too long.
module wb_dma_qch_ret_ctrl #(
  parameter int DRAIN_TIMEOUT  = 16,
  parameter int SAVE_CYCLES    = 2,
  parameter int RESTORE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       qreqn,
  input  logic       busy_i,
  output logic       qacceptn,
  output logic       qdeny,
  output logic       stall_o,
  output logic       pr_save_o,
  output logic       pr_restore_o,
  output logic       iso_o,
  output logic       clk_en_o,
  output logic       proto_err_o,
  output logic [2:0] state_o
);

  // state   | meaning
  // RUN     | normal operation, Q-channel in RUN
  // DRAIN   | new slave cycles stalled, waiting for busy_i to drop
  // SAVE    | retention save strobe
  // ISO     | isolation on, clock still running for one cycle
  // STOPPED | clock gated, request accepted
  // WAKE    | clock back on, restore strobe
  // UNISO   | isolation off, one cycle before RUN
  // DENY    | request refused, waiting for qreqn to return high
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    SAVE    = 3'd2,
    ISO     = 3'd3,
    STOPPED = 3'd4,
    WAKE    = 3'd5,
    UNISO   = 3'd6,
    DENY    = 3'd7
  } state_e;

  localparam int MAX_A = (DRAIN_TIMEOUT > SAVE_CYCLES) ? DRAIN_TIMEOUT : SAVE_CYCLES;
  localparam int MAX_C = (MAX_A > RESTORE_CYCLES) ? MAX_A : RESTORE_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] DRAIN_LAST   = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] SAVE_LAST    = CW'(SAVE_CYCLES - 1);
  localparam logic [CW-1:0] RESTORE_LAST = CW'(RESTORE_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          proto_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!qreqn) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          // A withdrawn request aborts before anything has been saved.
          if (qreqn) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            proto_err_q <= 1'b1;
          end else if (!busy_i) begin
            state_q <= SAVE;
            cnt_q   <= '0;
          end else if (cnt_q == DRAIN_LAST) begin
            state_q <= DENY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SAVE: begin
          if (qreqn) proto_err_q <= 1'b1;
          if (cnt_q == SAVE_LAST) begin
            state_q <= ISO;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ISO: begin
          if (qreqn) proto_err_q <= 1'b1;
          state_q <= STOPPED;
          cnt_q   <= '0;
        end
        STOPPED: begin
          if (qreqn) begin
            state_q <= WAKE;
            cnt_q   <= '0;
          end
        end
        WAKE: begin
          if (!qreqn) proto_err_q <= 1'b1;
          if (cnt_q == RESTORE_LAST) begin
            state_q <= UNISO;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        UNISO: begin
          if (!qreqn) proto_err_q <= 1'b1;
          state_q <= RUN;
          cnt_q   <= '0;
        end
        DENY: begin
          if (qreqn) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Pure decode of the registered state: no input reaches an output combinationally.
  assign stall_o      = (state_q != RUN) && (state_q != DENY);
  assign pr_save_o    = (state_q == SAVE);
  assign pr_restore_o = (state_q == WAKE);
  assign iso_o        = (state_q == ISO) || (state_q == STOPPED) || (state_q == WAKE);
  assign clk_en_o     = (state_q != STOPPED);
  assign qacceptn     = !((state_q == STOPPED) || (state_q == WAKE) || (state_q == UNISO));
  assign qdeny        = (state_q == DENY);
  assign proto_err_o  = proto_err_q;
  assign state_o      = state_q;

endmodule
